// File: rtl/adc_capture_train_if.sv
// Handshake-free data bundle between the ADC capture stage and its consumer.
// The master drives raw pins and control; the slave returns samples and checker status.
interface adc_capture_train_if #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned NCHAN = 2,
    parameter int unsigned ERR_W = 16
);
    logic [NCHAN*WIDTH-1:0] adc_in;
    logic                   train_en;
    logic                   clr_err;
    logic [NCHAN*WIDTH-1:0] adc_out;
    logic [NCHAN-1:0]       locked;
    logic [NCHAN*ERR_W-1:0] err_count;

    modport master (
        output adc_in,
        output train_en,
        output clr_err,
        input  adc_out,
        input  locked,
        input  err_count
    );

    modport slave (
        input  adc_in,
        input  train_en,
        input  clr_err,
        output adc_out,
        output locked,
        output err_count
    );
endinterface

// File: rtl/adc_capture_train.sv
// Two-stage multi-channel ADC capture with per-channel polarity correction and an
// independent training-pattern checker (lock flag + saturating error count) per channel.
module adc_capture_train #(
    parameter int unsigned      WIDTH    = 14,
    parameter int unsigned      NCHAN    = 2,
    parameter logic [NCHAN-1:0] INV_MASK = 2'b01,
    parameter logic [WIDTH-1:0] PAT_A    = 14'h2AAA,
    parameter logic [WIDTH-1:0] PAT_B    = 14'h1555,
    parameter int unsigned      LOCK_CNT = 64,
    parameter int unsigned      ERR_W    = 16
) (
    input logic                clk,
    input logic                rst,
    adc_capture_train_if.slave bus_io
);
    localparam int unsigned      RUN_W    = $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_CNT - 1);

    typedef enum logic [1:0] {StIdle, StSearch, StTrack, StLocked} state_e;

    logic [NCHAN*WIDTH-1:0] stage1_q;
    logic [NCHAN*WIDTH-1:0] stage2_q;
    logic [NCHAN*WIDTH-1:0] stage2_d;
    logic [NCHAN-1:0]       locked_w;
    logic [NCHAN*ERR_W-1:0] err_w;

    always_comb begin
        stage2_d = '0;
        for (int n = 0; n < NCHAN; n++) begin
            stage2_d[n*WIDTH +: WIDTH] = stage1_q[n*WIDTH +: WIDTH] ^ {WIDTH{INV_MASK[n]}};
        end
    end

    // Stage 1 stays a bare register so it can be packed into the input pad flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= bus_io.adc_in;
            stage2_q <= stage2_d;
        end
    end

    for (genvar n = 0; n < NCHAN; n++) begin : g_chk
        state_e           st_q;
        logic [RUN_W-1:0] run_q;
        logic [WIDTH-1:0] exp_q;
        logic             locked_q;
        logic [ERR_W-1:0] err_q;
        logic [WIDTH-1:0] word;
        logic             hit_a;
        logic             hit_b;
        logic             match;
        logic             tracking;
        logic             miss;

        assign word     = stage2_q[n*WIDTH +: WIDTH];
        assign hit_a    = (word == PAT_A);
        assign hit_b    = (word == PAT_B);
        assign match    = (word == exp_q);
        assign tracking = (st_q == StTrack) || (st_q == StLocked);
        assign miss     = bus_io.train_en && tracking && !match;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q     <= StIdle;
                run_q    <= '0;
                exp_q    <= PAT_A;
                locked_q <= 1'b0;
                err_q    <= '0;
            end else begin
                if (bus_io.clr_err) begin
                    err_q <= '0;
                end else if (miss && (err_q != '1)) begin
                    err_q <= err_q + 1'b1;
                end

                if (!bus_io.train_en) begin
                    st_q  <= StIdle;
                    run_q <= '0;
                end else begin
                    unique case (st_q)
                        StIdle: begin
                            st_q     <= StSearch;
                            locked_q <= 1'b0;
                        end
                        default: begin
                            if (hit_a || hit_b) begin
                                exp_q <= hit_a ? PAT_B : PAT_A;
                            end
                            if (tracking && match) begin
                                if (st_q == StTrack) begin
                                    run_q <= run_q + 1'b1;
                                    if (run_q == RUN_LAST) begin
                                        locked_q <= 1'b1;
                                        st_q     <= StLocked;
                                    end
                                end
                            end else begin
                                // A mismatching word that is itself a training word restarts the run.
                                locked_q <= 1'b0;
                                if (hit_a || hit_b) begin
                                    run_q <= RUN_W'(1);
                                    st_q  <= StTrack;
                                end else begin
                                    run_q <= '0;
                                    st_q  <= StSearch;
                                end
                            end
                        end
                    endcase
                end
            end
        end

        assign locked_w[n]                = locked_q;
        assign err_w[n*ERR_W +: ERR_W]    = err_q;
    end

    assign bus_io.adc_out   = stage2_q;
    assign bus_io.locked    = locked_w;
    assign bus_io.err_count = err_w;
endmodule

// File: tb/tb_adc_capture_train.sv
// Scoreboard bench for adc_capture_train: directed and randomised training traffic checked
// against a streak-length reference model of the pattern checkers.
module tb_adc_capture_train;
    localparam int unsigned     W       = 14;
    localparam int unsigned     NC      = 2;
    localparam int unsigned     EW      = 4;
    localparam int unsigned     LK      = 64;
    localparam logic [NC-1:0]   INV     = 2'b01;
    localparam logic [W-1:0]    PA      = 14'h2AAA;
    localparam logic [W-1:0]    PB      = 14'h1555;
    localparam int              ERR_MAX = (1 << EW) - 1;

    logic clk = 1'b0;
    logic rst;

    adc_capture_train_if #(.WIDTH(W), .NCHAN(NC), .ERR_W(EW)) bus ();

    adc_capture_train #(
        .WIDTH   (W),
        .NCHAN   (NC),
        .INV_MASK(INV),
        .PAT_A   (PA),
        .PAT_B   (PB),
        .LOCK_CNT(LK),
        .ERR_W   (EW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NC*W-1:0]  out;
        logic [NC-1:0]    lk;
        logic [NC*EW-1:0] err;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    bit   started = 1'b0;

    // Reference model: the checker is summarised by the length of the trailing run of
    // alternating training words seen since training was (re)enabled.
    logic [W-1:0] m_p1    [NC];
    logic [W-1:0] m_p2    [NC];
    logic [W-1:0] m_last  [NC];
    bit           m_act   [NC];
    int           m_streak[NC];
    bit           m_lk    [NC];
    int           m_err   [NC];

    bit te_s;
    bit ph [NC];

    function automatic logic [W-1:0] flip(input int ch, input logic [W-1:0] v);
        return v ^ {W{INV[ch]}};
    endfunction

    function automatic logic [W-1:0] pat(input bit p);
        return p ? PB : PA;
    endfunction

    function automatic void model_reset();
        for (int ch = 0; ch < NC; ch++) begin
            m_p1[ch] = '0; m_p2[ch] = '0; m_last[ch] = '0;
            m_act[ch] = 1'b0; m_streak[ch] = 0; m_lk[ch] = 1'b0; m_err[ch] = 0;
        end
    endfunction

    function automatic void model_edge(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                       input bit te, input bit clr);
        logic [W-1:0] ain [NC];
        logic [W-1:0] w;
        bit is_pat, cont, inc;
        ain[0] = a0;
        ain[1] = a1;
        for (int ch = 0; ch < NC; ch++) begin
            w = m_p2[ch];
            inc = 1'b0;
            if (!te) begin
                m_act[ch] = 1'b0;
                m_streak[ch] = 0;
            end else if (!m_act[ch]) begin
                m_act[ch] = 1'b1;
                m_lk[ch] = 1'b0;
                m_streak[ch] = 0;
            end else begin
                is_pat = (w == PA) || (w == PB);
                cont = is_pat && (m_streak[ch] > 0) && (w != m_last[ch]);
                inc = (m_streak[ch] > 0) && !cont;
                m_streak[ch] = !is_pat ? 0 : (cont ? m_streak[ch] + 1 : 1);
                m_last[ch] = w;
                m_lk[ch] = (m_streak[ch] >= LK);
            end
            if (clr) m_err[ch] = 0;
            else if (inc && m_err[ch] < ERR_MAX) m_err[ch] = m_err[ch] + 1;
            m_p2[ch] = flip(ch, m_p1[ch]);
            m_p1[ch] = ain[ch];
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        for (int ch = 0; ch < NC; ch++) begin
            e.out[ch*W +: W]   = m_p2[ch];
            e.lk[ch]           = m_lk[ch];
            e.err[ch*EW +: EW] = EW'(m_err[ch]);
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit r, input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input bit te, input bit clr);
        @(negedge clk);
        rst = r;
        bus.adc_in = {a1, a0};
        bus.train_en = te;
        bus.clr_err = clr;
        if (r) model_reset();
        else model_edge(a0, a1, te, clr);
        sbq.push_back(model_out());
        started = 1'b1;
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, flip(0, pat(ph[0])), flip(1, pat(ph[1])), te_s, 1'b0);
            ph[0] = !ph[0];
            ph[1] = !ph[1];
        end
    endtask

    task automatic bad0(input bit clr);
        step(1'b0, 14'h0000, flip(1, pat(ph[1])), te_s, clr);
        ph[1] = !ph[1];
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every clock edge after stimulus starts must match the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got empty queue, required an expectation");
                end else begin
                    e = sbq.pop_front();
                    check("adc_out", 64'(bus.adc_out), 64'(e.out));
                    check("locked", 64'(bus.locked), 64'(e.lk));
                    check("err_count", 64'(bus.err_count), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] a [NC];
        bit clr;
        int r;

        rst = 1'b1;
        bus.adc_in = '0;
        bus.train_en = 1'b0;
        bus.clr_err = 1'b0;
        te_s = 1'b0;
        ph[0] = 1'b0;
        ph[1] = 1'b0;
        model_reset();

        step(1'b1, 14'h0001, 14'h0001, 1'b0, 1'b0);
        step(1'b1, 14'h0001, 14'h0001, 1'b0, 1'b0);
        sample();
        check("rst_adc_out", 64'(bus.adc_out), 64'(0));

        // Capture latency: two edges, channel 0 inverted.
        step(1'b0, 14'h0001, 14'h0001, 1'b0, 1'b0);
        step(1'b0, 14'h0001, 14'h0001, 1'b0, 1'b0);
        sample();
        check("cap_ch0", 64'(bus.adc_out[W-1:0]), 64'(14'h3FFE));
        check("cap_ch1", 64'(bus.adc_out[2*W-1:W]), 64'(14'h0001));

        // Clean lock: pattern word 1 registers on edge 1, lock after edge LK+2.
        te_s = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 14'h0000, 14'h0000, 1'b1, 1'b0);
        for (int i = 1; i <= 80; i++) begin
            clean(1);
            if (i == LK + 1) begin
                sample();
                check("lock_early", 64'(bus.locked[0]), 64'(0));
            end
            if (i == LK + 2) begin
                sample();
                check("lock_edge", 64'(bus.locked[0]), 64'(1));
            end
        end
        sample();
        check("lock_no_err", 64'(bus.err_count[EW-1:0]), 64'(0));

        // Single bad word: drop and count two edges later, relock LK words after resumption.
        bad0(1'b0);
        clean(1);
        clean(1);
        sample();
        check("err_drop_locked", 64'(bus.locked[0]), 64'(0));
        check("err_count_one", 64'(bus.err_count[EW-1:0]), 64'(1));
        for (int j = 3; j <= LK + 2; j++) begin
            clean(1);
            if (j == LK + 1) begin
                sample();
                check("relock_early", 64'(bus.locked[0]), 64'(0));
            end
            if (j == LK + 2) begin
                sample();
                check("relock_edge", 64'(bus.locked[0]), 64'(1));
            end
        end

        // Phase slip: repeat a word.
        ph[0] = !ph[0];
        clean(3);
        sample();
        check("slip_err", 64'(bus.err_count[EW-1:0]), 64'(2));
        check("slip_unlock", 64'(bus.locked[0]), 64'(0));
        clean(LK + 4);

        // Saturation, then clear coinciding with an error.
        for (int i = 0; i < 20; i++) begin
            clean(2);
            bad0(1'b0);
        end
        clean(2);
        sample();
        check("err_saturated", 64'(bus.err_count[EW-1:0]), 64'(ERR_MAX));
        bad0(1'b0);
        clean(1);
        step(1'b0, flip(0, pat(ph[0])), flip(1, pat(ph[1])), te_s, 1'b1);
        ph[0] = !ph[0];
        ph[1] = !ph[1];
        sample();
        check("err_cleared", 64'(bus.err_count[EW-1:0]), 64'(0));

        // train_en drop holds lock; re-raise clears it.
        clean(LK + 4);
        sample();
        check("te_locked_before", 64'(bus.locked[0]), 64'(1));
        te_s = 1'b0;
        clean(5);
        sample();
        check("te_low_holds", 64'(bus.locked[0]), 64'(1));
        te_s = 1'b1;
        clean(1);
        sample();
        check("te_rise_clears", 64'(bus.locked[0]), 64'(0));
        clean(LK + 4);

        // Randomised traffic: stray words, phase slips, occasional enable toggles and clears.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) te_s = !te_s;
            clr = ($urandom_range(0, 199) == 0);
            for (int ch = 0; ch < NC; ch++) begin
                r = int'($urandom_range(0, 299));
                if (r < 2) begin
                    a[ch] = W'($urandom);
                end else if (r < 3) begin
                    a[ch] = flip(ch, pat(ph[ch]));
                end else begin
                    a[ch] = flip(ch, pat(ph[ch]));
                    ph[ch] = !ph[ch];
                end
            end
            step(1'b0, a[0], a[1], te_s, clr);
        end

        // Asynchronous reset in the middle of tracking.
        te_s = 1'b1;
        clean(12);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_adc_out", 64'(bus.adc_out), 64'(0));
        check("arst_locked", 64'(bus.locked), 64'(0));
        check("arst_err", 64'(bus.err_count), 64'(0));
        model_reset();
        sbq.push_back(model_out());
        step(1'b1, 14'h0000, 14'h0000, 1'b1, 1'b0);
        clean(LK + 6);

        sample();
        #1;
        check("sb_drain", 64'(sbq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
